sitcpxg_rx_stream_buffer: RTL and testbench
===========================================

// Module: sitcpxg_rx_stream_buffer
// PURPOSE
//  Parametrised TCP receive buffer for the 10GbE SiTCP core, in the XGMII_CLOCK domain.
//  - Owns the RX ring RAM; absorbs the core's byte-enabled big-endian writes.
//  - Returns the committed read address to the core and handles the RX-clear handshake.
//  - Drains data as a left-justified 64-bit valid/ready stream, with timed flush of partial words.
// PARAMETERS
//  ADDR_W     16  ring size = 2^ADDR_W bytes (12..16); RAM is 2^(ADDR_W-3) x 64
//  FLUSH_CYC  64  idle cycles (wr_ptr unchanged) before a partial word is emitted (>=2)
// PORTS
//  XGMII_CLOCK  in   1   single clock
//  RSTsn        in   1   synchronous reset, active low
//  RX_WADR      in   16  core write byte address (first enabled byte)
//  RX_WENB      in   8   byte enables; bit7 = lowest address; contiguous
//  RX_WDAT      in   64  write data, big endian
//  RX_RADR      out  16  committed read byte pointer, zero-extended; to core
//  RX_SIZE      out  16  constant 2^ADDR_W-16
//  RX_CLR_ENB   in   1   core permits buffer clear
//  RX_CLR_REQ   out  1   clear request to core, 1-cycle pulse
//  SESSION_EST  in   1   core session-established flag
//  CLR_CMD      in   1   user flush request, pulse
//  M_TDATA      out  64  stream data; first byte in [63:56]
//  M_TKEEP      out  8   leading-ones byte mask (FF,FE..80)
//  M_TVALID     out  1   stream valid
//  M_TREADY     in   1   stream ready
//  FILL         out  16  (wr_ptr-rd_ptr) mod 2^ADDR_W, zero-extended
//  OVERRUN      out  1   sticky: write landed in unconsumed data
// BEHAVIOUR
//  Reset: RX_RADR, RX_CLR_REQ, M_TDATA, M_TKEEP, M_TVALID, FILL and OVERRUN = 0; all pointers = 0.
//  Reset: pending-clear = 0.
//  Write: RX_WENB!=0 -> byte write to word RX_WADR[ADDR_W-1:3].
//   - Same edge: wr_ptr <= (RX_WADR + popcount(RX_WENB)) mod 2^ADDR_W.
//  OVERRUN sets if the new FILL exceeds RX_SIZE.
//  RAM: 1-cycle registered read, READ_FIRST (or NO_CHANGE) on same-address collision.
//  Pointers: iss_ptr = issued read byte pointer; rd_ptr = committed pointer (=RX_RADR).
//   - All pointers wrap mod 2^ADDR_W.
//  Issue rule, at off=iss_ptr[2:0]:
//   - Word complete if wr_ptr lies outside word iss_ptr[ADDR_W-1:3]: n = 8-off.
//   - Otherwise, if wr_ptr is unchanged for FLUSH_CYC cycles and wr_ptr!=iss_ptr: n = wr_ptr[2:0]-off.
//   - Otherwise no issue.
//   - Issue when the 2-entry output queue has a free slot; iss_ptr += n.
//   - n is frozen at issue, so bytes written later are never emitted early.
//  Output path: data shifted left by 8*off; TKEEP = n leading ones.
//   - Latency: 2 cycles from the wr_ptr update that completes a word to M_TVALID.
//  Throughput: 1 word/cycle sustained when data is available and M_TREADY=1.
//  Handshake (AXI-S): while M_TVALID=1 and M_TREADY=0, M_TDATA/M_TKEEP hold stable.
//   - On M_TVALID&M_TREADY: rd_ptr += n; RX_RADR updates the same edge.
//  Clear:
//   - pending-clear sets on CLR_CMD or on a falling edge of SESSION_EST.
//   - While pending and RX_CLR_ENB=1: RX_CLR_REQ=1 for exactly that cycle.
//   - Same edge: wr/iss/rd ptr <= 0, queue flushed (M_TVALID=0 next cycle), OVERRUN <= 0, pending <= 0.
//   - After a clear, the core restarts writes at address 0.
//   - A write in the clear cycle is discarded.
//  Simultaneous events:
//   - Write, issue and accept on one edge: each updates only its own pointer.
//   - FILL uses post-edge values.
// TESTING
//  T1 RSTsn=0 3 cycles, ADDR_W=16 -> all outputs 0, RX_SIZE=65520.
//  T2 writes WADR=0,8,16,24, WENB=FF, TREADY=1 -> 4 back-to-back beats.
//   - Each beat TKEEP=FF, data exact; RX_RADR=32 after last beat.
//  T3 WADR=0, WENB=F0, data 0xAABBCCDD_xxxxxxxx -> no beat for FLUSH_CYC-1 cycles.
//   - Then TDATA[63:32]=AABBCCDD, TKEEP=F0, RX_RADR=4.
//   - Next WADR=4, WENB=0F -> beat TKEEP=F0, RX_RADR=8.
//  T4 10 full words, TREADY=0 -> TVALID=1, TDATA stable, RX_RADR=0, FILL=80.
//   - Release TREADY -> 10 beats in 10 cycles.
//  T5 ADDR_W=12, 3x4080-byte random-length stream, random TREADY -> byte-exact output.
//   - Pointers wrap at 4096; OVERRUN=0.
//  T6 mid-stream CLR_CMD, RX_CLR_ENB=0 for 5 cycles then 1 -> one RX_CLR_REQ pulse.
//   - Next cycle: TVALID=0, RX_RADR=0, FILL=0; the RX_WENB=FF write in the REQ cycle is dropped.

Source files
------------

// File: rtl/sitcpxg_rx_stream_buffer.sv
// SiTCP-XG TCP receive ring buffer: absorbs the core's byte-enabled big-endian writes and
// drains them as a left-justified 64-bit valid/ready stream, flushing idle partial words.
module sitcpxg_rx_stream_buffer #(
    parameter int ADDR_W    = 16,
    parameter int FLUSH_CYC = 64
) (
    input  logic        XGMII_CLOCK,
    input  logic        RSTsn,
    input  logic [15:0] RX_WADR,
    input  logic [7:0]  RX_WENB,
    input  logic [63:0] RX_WDAT,
    output logic [15:0] RX_RADR,
    output logic [15:0] RX_SIZE,
    input  logic        RX_CLR_ENB,
    output logic        RX_CLR_REQ,
    input  logic        SESSION_EST,
    input  logic        CLR_CMD,
    output logic [63:0] M_TDATA,
    output logic [7:0]  M_TKEEP,
    output logic        M_TVALID,
    input  logic        M_TREADY,
    output logic [15:0] FILL,
    output logic        OVERRUN
);

    localparam int WORDS = 2 ** (ADDR_W - 3);
    localparam int CNT_W = $clog2(FLUSH_CYC);
    localparam logic [CNT_W-1:0]  IDLE_LOAD = CNT_W'(FLUSH_CYC - 1);
    localparam logic [ADDR_W-1:0] SIZE_A    = {{(ADDR_W-4){1'b1}}, 4'h0};

    logic [63:0]       mem [WORDS];
    logic [63:0]       ram_q;

    logic [ADDR_W-1:0] wr_ptr, iss_ptr, rd_ptr;
    logic [ADDR_W-1:0] wr_len, wr_nxt, rd_nxt, fill_nxt, fill_cur;
    logic [CNT_W-1:0]  idle_cnt;
    logic              pending, sess_d;
    logic              clr, wr_en, pop, issue, iss_avail, slot_free;
    logic [2:0]        off;
    logic [3:0]        iss_n;
    logic [1:0]        occ;

    logic              s1_vld;
    logic [2:0]        s1_off;
    logic [3:0]        s1_n;
    logic [63:0]       s1_data;
    logic [7:0]        s1_keep;

    logic              q1_vld;
    logic [63:0]       q1_data;
    logic [7:0]        q1_keep;
    logic [3:0]        q1_n;
    logic [3:0]        head_n;

    assign clr      = pending & RX_CLR_ENB;
    assign wr_en    = (RX_WENB != '0) && !clr;
    assign pop      = M_TVALID & M_TREADY;

    always_comb begin
        wr_len = '0;
        for (int i = 0; i < 8; i++) begin
            wr_len = wr_len + {{(ADDR_W-1){1'b0}}, RX_WENB[i]};
        end
    end

    assign wr_nxt   = wr_en ? RX_WADR[ADDR_W-1:0] + wr_len : wr_ptr;
    assign rd_nxt   = pop ? rd_ptr + {{(ADDR_W-4){1'b0}}, head_n} : rd_ptr;
    assign fill_nxt = wr_nxt - rd_nxt;
    assign fill_cur = wr_ptr - rd_ptr;

    assign RX_RADR    = 16'(rd_ptr);
    assign RX_SIZE    = 16'(SIZE_A);
    assign FILL       = 16'(fill_cur);
    assign RX_CLR_REQ = clr;

    // A word is issued whole once the writer has moved past it, or partially after an idle timeout.
    assign off = iss_ptr[2:0];
    always_comb begin
        iss_avail = 1'b0;
        iss_n     = 4'd0;
        if (wr_ptr[ADDR_W-1:3] != iss_ptr[ADDR_W-1:3]) begin
            iss_avail = 1'b1;
            iss_n     = 4'd8 - {1'b0, off};
        end else if (idle_cnt == '0 && wr_ptr != iss_ptr) begin
            iss_avail = 1'b1;
            iss_n     = {1'b0, wr_ptr[2:0]} - {1'b0, off};
        end
    end

    // The read in flight counts against the two output slots.
    assign occ       = {1'b0, M_TVALID} + {1'b0, q1_vld} + {1'b0, s1_vld};
    assign slot_free = (occ < 2'd2) || (occ == 2'd2 && pop);
    assign issue     = iss_avail && slot_free && !clr;

    assign s1_data = ram_q << {s1_off, 3'b000};
    assign s1_keep = ~(8'hFF >> s1_n);

    always_ff @(posedge XGMII_CLOCK) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (RX_WENB[i]) mem[RX_WADR[ADDR_W-1:3]][8*i +: 8] <= RX_WDAT[8*i +: 8];
            end
        end
        ram_q <= mem[iss_ptr[ADDR_W-1:3]];
    end

    always_ff @(posedge XGMII_CLOCK) begin
        if (!RSTsn) begin
            wr_ptr   <= '0;
            iss_ptr  <= '0;
            rd_ptr   <= '0;
            idle_cnt <= IDLE_LOAD;
            pending  <= 1'b0;
            sess_d   <= 1'b0;
            OVERRUN  <= 1'b0;
            s1_vld   <= 1'b0;
            s1_off   <= '0;
            s1_n     <= '0;
            q1_vld   <= 1'b0;
            q1_data  <= '0;
            q1_keep  <= '0;
            q1_n     <= '0;
            M_TVALID <= 1'b0;
            M_TDATA  <= '0;
            M_TKEEP  <= '0;
            head_n   <= '0;
        end else begin
            sess_d <= SESSION_EST;
            if (clr) begin
                wr_ptr   <= '0;
                iss_ptr  <= '0;
                rd_ptr   <= '0;
                idle_cnt <= IDLE_LOAD;
                pending  <= 1'b0;
                OVERRUN  <= 1'b0;
                s1_vld   <= 1'b0;
                q1_vld   <= 1'b0;
                M_TVALID <= 1'b0;
            end else begin
                pending <= pending | CLR_CMD | (sess_d & ~SESSION_EST);
                wr_ptr  <= wr_nxt;
                rd_ptr  <= rd_nxt;
                if (wr_en && fill_nxt > SIZE_A) OVERRUN <= 1'b1;

                if (wr_nxt != wr_ptr)    idle_cnt <= IDLE_LOAD;
                else if (idle_cnt != '0) idle_cnt <= idle_cnt - 1'b1;

                s1_vld <= issue;
                if (issue) begin
                    s1_off  <= off;
                    s1_n    <= iss_n;
                    iss_ptr <= iss_ptr + {{(ADDR_W-4){1'b0}}, iss_n};
                end

                // Head register plus one skid entry; head holds while stalled.
                if (!M_TVALID || pop) begin
                    if (q1_vld) begin
                        M_TVALID <= 1'b1;
                        M_TDATA  <= q1_data;
                        M_TKEEP  <= q1_keep;
                        head_n   <= q1_n;
                        q1_vld   <= s1_vld;
                        if (s1_vld) begin
                            q1_data <= s1_data;
                            q1_keep <= s1_keep;
                            q1_n    <= s1_n;
                        end
                    end else begin
                        M_TVALID <= s1_vld;
                        if (s1_vld) begin
                            M_TDATA <= s1_data;
                            M_TKEEP <= s1_keep;
                            head_n  <= s1_n;
                        end
                    end
                end else if (s1_vld) begin
                    q1_vld  <= 1'b1;
                    q1_data <= s1_data;
                    q1_keep <= s1_keep;
                    q1_n    <= s1_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_sitcpxg_rx_stream_buffer.sv
// Directed bench for sitcpxg_rx_stream_buffer: a byte scoreboard is filled on every write
// and drained against each accepted stream beat; pointer and handshake checks are inline.
module tb_sitcpxg_rx_stream_buffer;

    localparam int FC    = 64;
    localparam int TOTAL = 3 * 4080;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, clr_enb, clr_req, sess, clr_cmd, tvalid, tready, ovr;
    logic [15:0] wadr, radr, size, fill;
    logic [7:0]  wenb, tkeep;
    logic [63:0] wdat, tdata;

    logic        b_rstn, b_clr_enb, b_clr_req, b_sess, b_clr_cmd, b_tvalid, b_tready, b_ovr;
    logic [15:0] b_wadr, b_radr, b_size, b_fill;
    logic [7:0]  b_wenb, b_tkeep;
    logic [63:0] b_wdat, b_tdata;

    sitcpxg_rx_stream_buffer #(.ADDR_W(16), .FLUSH_CYC(FC)) dut (
        .XGMII_CLOCK(clk), .RSTsn(rstn), .RX_WADR(wadr), .RX_WENB(wenb), .RX_WDAT(wdat),
        .RX_RADR(radr), .RX_SIZE(size), .RX_CLR_ENB(clr_enb), .RX_CLR_REQ(clr_req),
        .SESSION_EST(sess), .CLR_CMD(clr_cmd), .M_TDATA(tdata), .M_TKEEP(tkeep),
        .M_TVALID(tvalid), .M_TREADY(tready), .FILL(fill), .OVERRUN(ovr)
    );

    sitcpxg_rx_stream_buffer #(.ADDR_W(12), .FLUSH_CYC(FC)) dut12 (
        .XGMII_CLOCK(clk), .RSTsn(b_rstn), .RX_WADR(b_wadr), .RX_WENB(b_wenb), .RX_WDAT(b_wdat),
        .RX_RADR(b_radr), .RX_SIZE(b_size), .RX_CLR_ENB(b_clr_enb), .RX_CLR_REQ(b_clr_req),
        .SESSION_EST(b_sess), .CLR_CMD(b_clr_cmd), .M_TDATA(b_tdata), .M_TKEEP(b_tkeep),
        .M_TVALID(b_tvalid), .M_TREADY(b_tready), .FILL(b_fill), .OVERRUN(b_ovr)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input bit which, input logic [63:0] data, input logic [7:0] keep);
        int n;
        logic [63:0] exp_w, mask;
        logic [7:0]  exp_k;
        bit under;
        n = $countones(keep);
        exp_w = '0;
        mask  = '0;
        under = 1'b0;
        exp_k = (n == 0) ? 8'hFF : ~(8'hFF >> n);
        for (int i = 0; i < n; i++) begin
            mask[63-8*i -: 8] = 8'hFF;
            if (!which) begin
                if (sb_a.size() == 0) under = 1'b1;
                else exp_w[63-8*i -: 8] = sb_a.pop_front();
            end else begin
                if (sb_b.size() == 0) under = 1'b1;
                else exp_w[63-8*i -: 8] = sb_b.pop_front();
            end
        end
        check(which ? "beat12_keep" : "beat_keep", {56'b0, keep}, {56'b0, exp_k});
        check(which ? "beat12_underflow" : "beat_underflow", {63'b0, under}, 64'd0);
        check(which ? "beat12_data" : "beat_data", data & mask, exp_w);
    endtask

    always @(negedge clk) if (rstn && tvalid && tready) beat(1'b0, tdata, tkeep);
    always @(negedge clk) if (b_rstn && b_tvalid && b_tready) beat(1'b1, b_tdata, b_tkeep);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [15:0] a, input logic [7:0] e, input logic [63:0] d, input bit push);
        wadr = a;
        wenb = e;
        wdat = d;
        if (push) for (int i = 7; i >= 0; i--) if (e[i]) sb_a.push_back(d[8*i +: 8]);
    endtask

    task automatic reset_a();
        rstn = 1'b0; wenb = '0; tready = 1'b0; clr_cmd = 1'b0; clr_enb = 1'b0; sess = 1'b1;
        repeat (3) tick();
        rstn = 1'b1;
        sb_a.delete();
        tick();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] cap, d;
        logic [11:0] wp, used;
        logic [7:0]  enb;
        bit          flag;
        int          w, sent, pause, cyc, len;

        rstn = 1'b0; wadr = '0; wenb = '0; wdat = '0; clr_enb = 1'b0; sess = 1'b1;
        clr_cmd = 1'b0; tready = 1'b0;
        b_rstn = 1'b0; b_wadr = '0; b_wenb = '0; b_wdat = '0; b_clr_enb = 1'b0; b_sess = 1'b1;
        b_clr_cmd = 1'b0; b_tready = 1'b0;

        // T1: reset state
        repeat (3) tick();
        check("t1_radr", radr, 0);
        check("t1_clr_req", clr_req, 0);
        check("t1_tdata", tdata, 0);
        check("t1_tkeep", tkeep, 0);
        check("t1_tvalid", tvalid, 0);
        check("t1_fill", fill, 0);
        check("t1_overrun", ovr, 0);
        check("t1_size", size, 16'd65520);
        check("t1_size12", b_size, 16'd4080);
        rstn = 1'b1;
        b_rstn = 1'b1;
        tick();

        // T2: four full words back to back
        reset_a();
        tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_wr(16'(8 * k), 8'hFF, {$urandom, $urandom}, 1'b1);
            tick();
            if (k == 1) check("t2_not_yet", tvalid, 0);
            if (k == 2) check("t2_latency", tvalid, 1);
        end
        wenb = '0;
        for (int j = 0; j < 3; j++) begin
            check("t2_back_to_back", tvalid, 1);
            tick();
        end
        check("t2_drained", tvalid, 0);
        check("t2_radr", radr, 16'd32);
        check("t2_fill", fill, 0);

        // T3: partial word flushed after idle timeout, remainder completes it
        reset_a();
        tready = 1'b1;
        set_wr(16'd0, 8'hF0, 64'hAABBCCDD_11223344, 1'b1);
        tick();
        wenb = '0;
        flag = 1'b1;
        repeat (FC - 1) begin
            tick();
            if (tvalid) flag = 1'b0;
        end
        check("t3_quiet", {63'b0, flag}, 1);
        w = 0;
        while (!tvalid && w < 10) begin tick(); w++; end
        check("t3_flush_seen", tvalid, 1);
        check("t3_keep", tkeep, 8'hF0);
        check("t3_data_hi", tdata[63:32], 32'hAABBCCDD);
        tick();
        check("t3_radr4", radr, 16'd4);
        set_wr(16'd4, 8'h0F, 64'h99999999_55667788, 1'b1);
        tick();
        wenb = '0;
        w = 0;
        while (!tvalid && w < 10) begin tick(); w++; end
        check("t3_second_seen", tvalid, 1);
        check("t3_keep2", tkeep, 8'hF0);
        check("t3_data2_hi", tdata[63:32], 32'h55667788);
        tick();
        check("t3_radr8", radr, 16'd8);

        // T4: backpressure then release
        reset_a();
        tready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            set_wr(16'(8 * k), 8'hFF, {$urandom, $urandom}, 1'b1);
            tick();
        end
        wenb = '0;
        repeat (4) tick();
        check("t4_valid", tvalid, 1);
        cap = tdata;
        repeat (3) tick();
        check("t4_stable", tdata, cap);
        check("t4_radr", radr, 0);
        check("t4_fill", fill, 16'd80);
        tready = 1'b1;
        flag = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!tvalid) flag = 1'b0;
            tick();
        end
        check("t4_ten_in_ten", {63'b0, flag}, 1);
        check("t4_done", tvalid, 0);
        check("t4_radr80", radr, 16'd80);
        check("t4_sb_empty", 64'(sb_a.size()), 0);

        // T5: random stream through the 4 KiB ring
        wp = '0; sent = 0; pause = 0; cyc = 0;
        while ((sent < TOTAL || sb_b.size() != 0) && cyc < 60000) begin
            b_tready = ($urandom_range(0, 3) != 0);
            b_wenb = '0;
            if (pause > 0) begin
                pause--;
            end else if (sent < TOTAL && $urandom_range(0, 3) != 0) begin
                len = $urandom_range(1, 8 - int'(wp[2:0]));
                if (len > TOTAL - sent) len = TOTAL - sent;
                used = wp - b_radr[11:0];
                if (int'(used) + len <= 4080) begin
                    enb = 8'hFF << (8 - len);
                    enb = enb >> wp[2:0];
                    d = {$urandom, $urandom};
                    b_wadr = {4'b0, wp};
                    b_wenb = enb;
                    b_wdat = d;
                    for (int i = 7; i >= 0; i--) if (enb[i]) sb_b.push_back(d[8*i +: 8]);
                    wp = wp + 12'(len);
                    sent += len;
                    if ($urandom_range(0, 199) == 0) pause = FC + 16;
                end
            end
            tick();
            cyc++;
        end
        b_wenb = '0;
        b_tready = 1'b1;
        repeat (2) tick();
        check("t5_timeout", {63'b0, cyc < 60000}, 1);
        check("t5_sb_empty", 64'(sb_b.size()), 0);
        check("t5_overrun", b_ovr, 0);
        check("t5_radr_wrap", b_radr, 16'd4048);
        check("t5_fill", b_fill, 0);

        // T6: clear handshake mid-stream
        reset_a();
        tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_wr(16'(8 * k), 8'hFF, {$urandom, $urandom}, 1'b1);
            tick();
        end
        wenb = '0;
        clr_cmd = 1'b1;
        tick();
        clr_cmd = 1'b0;
        flag = 1'b1;
        repeat (5) begin
            if (clr_req) flag = 1'b0;
            tick();
        end
        check("t6_no_req_while_disabled", {63'b0, flag}, 1);
        check("t6_valid_before", tvalid, 1);
        clr_enb = 1'b1;
        set_wr(16'd24, 8'hFF, 64'hDEADBEEF_CAFEF00D, 1'b0);
        #1;
        check("t6_req_pulse", clr_req, 1);
        tick();
        wenb = '0;
        clr_enb = 1'b0;
        sb_a.delete();
        check("t6_valid_cleared", tvalid, 0);
        check("t6_radr", radr, 0);
        check("t6_fill", fill, 0);
        check("t6_req_gone", clr_req, 0);
        tready = 1'b1;
        flag = 1'b1;
        repeat (5) begin
            tick();
            if (tvalid) flag = 1'b0;
        end
        check("t6_dropped_write", {63'b0, flag}, 1);
        set_wr(16'd0, 8'hFF, 64'h0123456789ABCDEF, 1'b1);
        tick();
        wenb = '0;
        w = 0;
        while (!tvalid && w < 10) begin tick(); w++; end
        check("t6_restart_beat", tdata, 64'h0123456789ABCDEF);
        tick();
        check("t6_restart_radr", radr, 16'd8);

        // Session drop requests a clear as well
        clr_enb = 1'b1;
        sess = 1'b0;
        tick();
        check("t6_sess_req", clr_req, 1);
        tick();
        check("t6_sess_req_done", clr_req, 0);
        check("t6_sess_radr", radr, 0);
        sess = 1'b1;
        clr_enb = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
